// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_ctrl
// Brief    : Programmable serial pattern detector with arm/abort run control
// Revision : 1.0
// ============================================================================
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we_i,
    input  logic [MAX_LEN-1:0]           cfg_pattern_i,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len_i,
    input  logic                         cfg_overlap_i,
    input  logic [CNT_W-1:0]             cfg_target_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic                         in_valid_i,
    input  logic                         in_i,
    output logic                         busy_o,
    output logic                         hit_o,
    output logic [CNT_W-1:0]             match_cnt_o,
    output logic                         done_o,
    output logic                         cfg_err_o
);

    localparam int               LEN_W    = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [MAX_LEN-1:0]   pat_q,   pat_d;
    logic [LEN_W-1:0]     len_q,   len_d;
    logic                 ovl_q,   ovl_d;
    logic [CNT_W-1:0]     tgt_q,   tgt_d;
    logic                 err_q,   err_d;
    logic [MAX_LEN-1:0]   hist_q,  hist_d;
    logic [LEN_W-1:0]     fill_q,  fill_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic                 hit_q,   hit_d;

    logic [MAX_LEN-1:0]   w_hist_shift;
    logic [LEN_W-1:0]     w_fill_inc;
    logic [MAX_LEN-1:0]   w_len_mask;
    logic                 w_match;
    logic [CNT_W-1:0]     w_cnt_inc;

    assign w_hist_shift = {hist_q[MAX_LEN-2:0], in_i};
    assign w_fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);
    assign w_cnt_inc    = cnt_q + CNT_W'(1);

    // Only the low len_q bits of the history take part in the comparison.
    always_comb begin
        w_len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_len_mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign w_match = (w_fill_inc >= len_q) &&
                     (((w_hist_shift ^ pat_q) & w_len_mask) == '0);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        tgt_d   = tgt_q;
        err_d   = err_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_we_i) begin
                    pat_d = cfg_pattern_i;
                    len_d = cfg_len_i;
                    ovl_d = cfg_overlap_i;
                    tgt_d = cfg_target_i;
                    err_d = (cfg_len_i == '0) || (cfg_len_i > FILL_MAX);
                end
                // The error gate applies to arming from IDLE; a restart from DONE is unconditional.
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (start_i && ((state_q == S_DONE) || !err_q)) begin
                    state_d = S_RUN;
                    hist_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (in_valid_i) begin
                    hist_d = w_hist_shift;
                    fill_d = w_fill_inc;
                    if (w_match) begin
                        hit_d = 1'b1;
                        cnt_d = w_cnt_inc;
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
                        if ((tgt_q != '0) && (w_cnt_inc == tgt_q)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            err_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
        end
    end

    assign busy_o      = (state_q == S_RUN);
    assign done_o      = (state_q == S_DONE);
    assign hit_o       = hit_q;
    assign match_cnt_o = cnt_q;
    assign cfg_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_ctrl
// Brief    : Scoreboard bench for seq_det_ctrl
// Revision : 1.0
// ============================================================================
module tb_seq_det_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cfg_we;
    logic [MAX_LEN-1:0]   cfg_pattern;
    logic [LEN_W-1:0]     cfg_len;
    logic                 cfg_overlap;
    logic [CNT_W-1:0]     cfg_target;
    logic                 start;
    logic                 abort;
    logic                 in_valid;
    logic                 in_b;
    logic                 busy;
    logic                 hit;
    logic [CNT_W-1:0]     match_cnt;
    logic                 done;
    logic                 cfg_err;

    seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_we_i      (cfg_we),
        .cfg_pattern_i (cfg_pattern),
        .cfg_len_i     (cfg_len),
        .cfg_overlap_i (cfg_overlap),
        .cfg_target_i  (cfg_target),
        .start_i       (start),
        .abort_i       (abort),
        .in_valid_i    (in_valid),
        .in_i          (in_b),
        .busy_o        (busy),
        .hit_o         (hit),
        .match_cnt_o   (match_cnt),
        .done_o        (done),
        .cfg_err_o     (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             hit;
        logic [CNT_W-1:0] cnt;
        logic             busy;
        logic             done;
        logic             err;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   hit_seen = 0;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    int               m_state;
    logic [MAX_LEN-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    int               m_tgt;
    bit               m_err;
    bit               m_hist[$];
    int               m_fill;
    int               m_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_pat   = '0;
        m_len   = 0;
        m_ovl   = 1'b0;
        m_tgt   = 0;
        m_err   = 1'b0;
        m_hist.delete();
        m_fill  = 0;
        m_cnt   = 0;
    endtask

    // Reference model: newest bit at the back of m_hist; pattern bit 0 is the last bit received.
    task automatic model_step(output exp_t e);
        bit old_err;
        bit nh;
        bit m;
        old_err = m_err;
        nh      = 1'b0;
        if (m_state != M_RUN) begin
            if (cfg_we) begin
                m_pat = cfg_pattern;
                m_len = int'(cfg_len);
                m_ovl = cfg_overlap;
                m_tgt = int'(cfg_target);
                m_err = (m_len == 0) || (m_len > MAX_LEN);
            end
            if (abort) begin
                m_state = M_IDLE;
            end else if (start && (m_state == M_DONE || !old_err)) begin
                m_state = M_RUN;
                m_hist.delete();
                m_fill  = 0;
                m_cnt   = 0;
            end
        end else if (abort) begin
            m_state = M_IDLE;
        end else if (in_valid) begin
            m_hist.push_back(in_b);
            if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
            if (m_fill < MAX_LEN) m_fill++;
            m = (m_fill >= m_len);
            for (int k = 0; k < m_len && m; k++) begin
                if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) m = 1'b0;
            end
            if (m) begin
                nh    = 1'b1;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                if (!m_ovl) m_fill = 0;
                if (m_tgt != 0 && m_cnt == m_tgt) m_state = M_DONE;
            end
        end
        e.hit  = nh;
        e.cnt  = CNT_W'(m_cnt);
        e.busy = (m_state == M_RUN);
        e.done = (m_state == M_DONE);
        e.err  = m_err;
    endtask

    task automatic tick();
        exp_t e;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("hit",  hit,       e.hit);
        chk("cnt",  match_cnt, e.cnt);
        chk("busy", busy,      e.busy);
        chk("done", done,      e.done);
        chk("err",  cfg_err,   e.err);
        if (hit) hit_seen++;
    endtask

    task automatic do_cfg(input logic [MAX_LEN-1:0] p, input int l, input bit o, input int t);
        cfg_we      = 1'b1;
        cfg_pattern = p;
        cfg_len     = LEN_W'(l);
        cfg_overlap = o;
        cfg_target  = CNT_W'(t);
        tick();
        cfg_we      = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic send_seq(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            in_b     = bits[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) begin
            in_b     = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy,      0);
        chk({tag, "_hit"},  hit,       0);
        chk({tag, "_cnt"},  match_cnt, 0);
        chk({tag, "_done"}, done,      0);
        chk({tag, "_err"},  cfg_err,   0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        cfg_we      = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cfg_target  = '0;
        start       = 1'b0;
        abort       = 1'b0;
        in_valid    = 1'b0;
        in_b        = 1'b0;
        model_reset();
        #12;
        chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Overlapping matches on 1011 with unlimited target.
        do_cfg(8'h0B, 4, 1'b1, 0);
        do_start();
        hit_seen = 0;
        send_seq(32'b1011011, 7);
        chk("ovl_hits", hit_seen, 2);
        chk("ovl_cnt",  match_cnt, 2);
        chk("ovl_busy", busy, 1);
        chk("ovl_done", done, 0);

        // Non-overlapping: second match needs four fresh bits.
        do_abort();
        do_cfg(8'h0B, 4, 1'b0, 0);
        do_start();
        hit_seen = 0;
        send_seq(32'b1011011, 7);
        chk("novl_hits1", hit_seen, 1);
        chk("novl_cnt1",  match_cnt, 1);
        send_seq(32'b011, 3);
        chk("novl_hits2", hit_seen, 2);
        chk("novl_cnt2",  match_cnt, 2);

        // Target reached: hit and done together, then no further sampling.
        do_abort();
        do_cfg(8'h0B, 4, 1'b1, 2);
        do_start();
        hit_seen = 0;
        send_seq(32'b1011011, 7);
        chk("tgt_done", done, 1);
        chk("tgt_busy", busy, 0);
        chk("tgt_cnt",  match_cnt, 2);
        send_seq(32'b1011, 4);
        chk("tgt_hits", hit_seen, 2);
        chk("tgt_hold", match_cnt, 2);
        do_start();
        chk("restart_cnt",  match_cnt, 0);
        chk("restart_busy", busy, 1);

        // Configuration error gating and RUN-time write protection.
        do_abort();
        do_cfg(8'h00, 0, 1'b0, 0);
        chk("err_set", cfg_err, 1);
        do_start();
        chk("err_nostart", busy, 0);
        do_cfg(8'h05, 3, 1'b0, 0);
        chk("err_clr", cfg_err, 0);
        do_start();
        chk("err_start", busy, 1);
        do_cfg(8'h00, 0, 1'b1, 5);
        chk("run_cfg_ignored", cfg_err, 0);
        hit_seen = 0;
        send_seq(32'b101, 3);
        chk("run_cfg_pat", hit_seen, 1);

        // Gaps in in_valid; abort and start together stays idle.
        do_abort();
        do_cfg(8'h0B, 4, 1'b1, 0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_wins", busy, 0);
        do_start();
        hit_seen = 0;
        send_seq(32'b101, 3);
        for (int i = 0; i < 5; i++) begin
            in_b = 1'($urandom_range(0, 1));
            tick();
        end
        send_seq(32'b1, 1);
        chk("gap_hits", hit_seen, 1);
        chk("gap_cnt",  match_cnt, 1);

        // Abort on the completing bit suppresses hit and count.
        send_seq(32'b01, 2);
        in_b     = 1'b1;
        in_valid = 1'b1;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_hits", hit_seen, 1);
        chk("abort_cnt",  match_cnt, 1);
        chk("abort_idle", busy, 0);

        // Counter wrap with unlimited target: 259 matches on a stream of ones.
        do_cfg(8'h03, 2, 1'b1, 0);
        do_start();
        for (int i = 0; i < 260; i++) begin
            in_b     = 1'b1;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("wrap_cnt",  match_cnt, 3);
        chk("wrap_busy", busy, 1);

        // Random streams, short non-overlap and full-length overlap patterns.
        do_abort();
        do_cfg(8'h06, 3, 1'b0, 0);
        do_start();
        send_rand(150);
        do_abort();
        do_cfg(8'hA5, MAX_LEN, 1'b1, 0);
        do_start();
        send_rand(150);

        // Asynchronous reset mid-run.
        send_seq(32'b1011, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_q_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
